// File: rtl/ddr3_cmd_sched.sv
// Closed-page DDR3 command scheduler: arbitrates a read and a write port, issues ACT then
// RD/WR with auto-precharge, and inserts periodic PRE-all + REF sequences.
module ddr3_cmd_sched #(
  parameter int unsigned T_RCD  = 5,
  parameter int unsigned T_RW   = 12,
  parameter int unsigned T_RP   = 5,
  parameter int unsigned T_RFC  = 44,
  parameter int unsigned T_REFI = 780
) (
  input  logic        cpu_clk,
  input  logic        RESET_N,
  input  logic        rd_req,
  input  logic [27:0] rd_addr,
  output logic        rd_gnt,
  output logic        rd_done,
  input  logic        wr_req,
  input  logic [27:0] wr_addr,
  output logic        wr_gnt,
  output logic        wr_done,
  output logic        CS_N,
  output logic        RAS_N,
  output logic        CAS_N,
  output logic        WE_N,
  output logic [2:0]  BA,
  output logic [14:0] ADDR,
  output logic        busy,
  output logic        ref_miss
);

  localparam int unsigned WaitW = 16;
  localparam int unsigned RefW  = $clog2(T_REFI);

  localparam logic [3:0] CmdNop = 4'b0111;
  localparam logic [3:0] CmdAct = 4'b0011;
  localparam logic [3:0] CmdRd  = 4'b0101;
  localparam logic [3:0] CmdWr  = 4'b0100;
  localparam logic [3:0] CmdPre = 4'b0010;
  localparam logic [3:0] CmdRef = 4'b0001;

  typedef enum logic [3:0] {
    StIdle, StAct, StTrcdWait, StRw, StTrwWait, StPreAll, StTrpWait, StRef, StTrfcWait
  } state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [RefW-1:0]    ref_cnt_q, ref_cnt_d;
  logic               ref_pending_q, ref_pending_d;
  logic               ref_miss_q, ref_miss_d;
  logic               last_wr_q, last_wr_d;
  logic [27:0]        acc_addr_q, acc_addr_d;
  logic               acc_wr_q, acc_wr_d;
  logic               ref_wrap;

  logic [3:0]  cmd_q, cmd_d;
  logic [2:0]  ba_q, ba_d;
  logic [14:0] addr_q, addr_d;
  logic        rd_gnt_q, rd_gnt_d, wr_gnt_q, wr_gnt_d;
  logic        rd_done_q, rd_done_d, wr_done_q, wr_done_d;
  logic        busy_q, busy_d;

  // State register, including all registered outputs.
  always_ff @(posedge cpu_clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= StIdle;
      wait_q        <= '0;
      ref_cnt_q     <= '0;
      ref_pending_q <= 1'b0;
      ref_miss_q    <= 1'b0;
      last_wr_q     <= 1'b1;
      acc_addr_q    <= '0;
      acc_wr_q      <= 1'b0;
      cmd_q         <= CmdNop;
      ba_q          <= '0;
      addr_q        <= '0;
      rd_gnt_q      <= 1'b0;
      wr_gnt_q      <= 1'b0;
      rd_done_q     <= 1'b0;
      wr_done_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      ref_cnt_q     <= ref_cnt_d;
      ref_pending_q <= ref_pending_d;
      ref_miss_q    <= ref_miss_d;
      last_wr_q     <= last_wr_d;
      acc_addr_q    <= acc_addr_d;
      acc_wr_q      <= acc_wr_d;
      cmd_q         <= cmd_d;
      ba_q          <= ba_d;
      addr_q        <= addr_d;
      rd_gnt_q      <= rd_gnt_d;
      wr_gnt_q      <= wr_gnt_d;
      rd_done_q     <= rd_done_d;
      wr_done_q     <= wr_done_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state logic. Wait counters load N-2 so each wait state lasts N-1 cycles.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    acc_addr_d = acc_addr_q;
    acc_wr_d   = acc_wr_q;
    last_wr_d  = last_wr_q;
    unique case (state_q)
      StIdle: begin
        if (ref_pending_q) begin
          state_d = StPreAll;
        end else if (rd_req && (!wr_req || last_wr_q)) begin
          state_d    = StAct;
          acc_addr_d = rd_addr;
          acc_wr_d   = 1'b0;
          last_wr_d  = 1'b0;
        end else if (wr_req) begin
          state_d    = StAct;
          acc_addr_d = wr_addr;
          acc_wr_d   = 1'b1;
          last_wr_d  = 1'b1;
        end
      end
      StAct: begin
        state_d = StTrcdWait;
        wait_d  = WaitW'(T_RCD - 2);
      end
      StTrcdWait: begin
        if (wait_q == '0) state_d = StRw;
        else              wait_d  = wait_q - 1'b1;
      end
      StRw: begin
        state_d = StTrwWait;
        wait_d  = WaitW'(T_RW - 2);
      end
      StTrwWait: begin
        if (wait_q == '0) state_d = StIdle;
        else              wait_d  = wait_q - 1'b1;
      end
      StPreAll: begin
        state_d = StTrpWait;
        wait_d  = WaitW'(T_RP - 2);
      end
      StTrpWait: begin
        if (wait_q == '0) state_d = StRef;
        else              wait_d  = wait_q - 1'b1;
      end
      StRef: begin
        state_d = StTrfcWait;
        wait_d  = WaitW'(T_RFC - 2);
      end
      StTrfcWait: begin
        if (wait_q == '0) state_d = StIdle;
        else              wait_d  = wait_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Refresh timer; a wrap that finds a refresh still pending is an overrun.
  always_comb begin
    ref_wrap  = (ref_cnt_q == RefW'(T_REFI - 1));
    ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;
    ref_pending_d = ref_pending_q;
    if (ref_wrap)              ref_pending_d = 1'b1;
    else if (state_d == StRef) ref_pending_d = 1'b0;
    ref_miss_d = ref_miss_q | (ref_wrap & ref_pending_q);
  end

  // Outputs are decoded from the next state so the registers line up with state_q.
  always_comb begin
    cmd_d     = CmdNop;
    ba_d      = '0;
    addr_d    = '0;
    rd_gnt_d  = 1'b0;
    wr_gnt_d  = 1'b0;
    rd_done_d = 1'b0;
    wr_done_d = 1'b0;
    busy_d    = (state_d != StIdle);
    unique case (state_d)
      StAct: begin
        cmd_d    = CmdAct;
        ba_d     = acc_addr_d[27:25];
        addr_d   = acc_addr_d[24:10];
        rd_gnt_d = !acc_wr_d;
        wr_gnt_d = acc_wr_d;
      end
      StRw: begin
        cmd_d  = acc_wr_d ? CmdWr : CmdRd;
        ba_d   = acc_addr_d[27:25];
        addr_d = {4'b0000, 1'b1, acc_addr_d[9:0]};
      end
      StTrwWait: begin
        rd_done_d = (wait_d == '0) && !acc_wr_d;
        wr_done_d = (wait_d == '0) && acc_wr_d;
      end
      StPreAll: begin
        cmd_d  = CmdPre;
        addr_d = 15'h0400;
      end
      StRef: cmd_d = CmdRef;
      default: ;
    endcase
  end

  assign {CS_N, RAS_N, CAS_N, WE_N} = cmd_q;
  assign BA       = ba_q;
  assign ADDR     = addr_q;
  assign rd_gnt   = rd_gnt_q;
  assign wr_gnt   = wr_gnt_q;
  assign rd_done  = rd_done_q;
  assign wr_done  = wr_done_q;
  assign busy     = busy_q;
  assign ref_miss = ref_miss_q;

endmodule

// File: doc/ddr3_cmd_sched.md
Name: ddr3_cmd_sched

Overview:
Closed-page command scheduler that sits between two CPU-side requesters (read port, write port) and the DDR3 memory controller's command inputs. It arbitrates the two ports, generates ACT then RD/WR-with-auto-precharge sequences with tRCD and recovery spacing, and inserts periodic PRE-all and REF sequences. It drives {CS_N,RAS_N,CAS_N,WE_N}, BA and ADDR toward the controller.

Parameters:
T_RCD, 5, cycles from ACT to RD/WR (min 2)
T_RW, 12, cycles from RD/WR until the bank is closed and the next command is allowed; covers burst, write recovery and auto-precharge (min 2)
T_RP, 5, cycles from PRE-all to REF (min 2)
T_RFC, 44, cycles from REF until the next command (min 2)
T_REFI, 780, refresh interval in cycles (must exceed T_RCD+T_RW+T_RP+T_RFC)

Ports:
cpu_clk  in  1  clock
RESET_N  in  1  asynchronous active-low reset
rd_req  in  1  read request, held until rd_gnt
rd_addr  in  28  {bank[27:25], row[24:10], col[9:0]}
rd_gnt  out  1  one-cycle pulse, coincident with the ACT for the read
rd_done  out  1  one-cycle pulse, read access complete
wr_req  in  1  write request, held until wr_gnt
wr_addr  in  28  same format as rd_addr
wr_gnt  out  1  one-cycle pulse, coincident with the ACT for the write
wr_done  out  1  one-cycle pulse, write access complete
CS_N, RAS_N, CAS_N, WE_N  out  1 each  command to controller
BA  out  3  bank address
ADDR  out  15  row/column address
busy  out  1  high whenever state != IDLE
ref_miss  out  1  sticky refresh-overrun error

Behaviour:
- Command encodings {CS_N,RAS_N,CAS_N,WE_N}: NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010, REF 0001.
- All outputs are registered. Each non-NOP command lasts exactly one cycle; every other cycle is NOP.
- Reset (asynchronous, any state): command NOP, BA=0, ADDR=0, all gnt/done=0, busy=0, ref_miss=0, state IDLE, refresh counter=0, ref_pending=0, round-robin pointer = "write served last".
- States: IDLE, ACT, TRCD_WAIT, RW, TRW_WAIT, PRE_ALL, TRP_WAIT, REF, TRFC_WAIT.
- IDLE decision priority at each edge: ref_pending, then round-robin between rd_req and wr_req, else stay in IDLE.
  - Round robin: when both ports request, serve the port not served last. A single requester always wins.
- Access sequence:
  - Request address is latched on the edge that leaves IDLE.
  - ACT cycle: BA=bank, ADDR=row, matching gnt=1.
  - TRCD_WAIT lasts T_RCD-1 cycles.
  - RW cycle: RD or WR, BA=bank, ADDR={4'b0,1'b1,col}. Bit 10 is always set (auto-precharge).
  - TRW_WAIT lasts T_RW-1 cycles. The matching done pulse is asserted in its last cycle, then the state returns to IDLE.
  - ACT-to-RD/WR spacing is exactly T_RCD. RD/WR-to-next-command spacing is at least T_RW.
- Refresh sequence:
  - PRE_ALL cycle: PRE with ADDR[10]=1, BA=0.
  - TRP_WAIT lasts T_RP-1 cycles.
  - REF cycle: ref_pending clears.
  - TRFC_WAIT lasts T_RFC-1 cycles, then IDLE.
- Refresh timer:
  - Counter increments every cycle and wraps from T_REFI-1 to 0. ref_pending sets on the wrap.
  - If ref_pending is still set at the next wrap, ref_miss sets and stays set until reset.
  - A pending refresh never aborts an access in progress; it is served at the next IDLE decision.
- Requests are sampled only in IDLE. A requester holding req past its gnt is treated as a new request at the next IDLE.
- Address width: BA=addr[27:25]; row ADDR=addr[24:10]; column occupies ADDR[9:0].

Test Plan:
- Reset: RESET_N=0 mid-operation -> same cycle command=0111, busy=0, gnt/done=0. After release with no requests, command stays NOP until the first refresh.
- Single read: rd_addr={3'd3,15'h1234,10'h0AB}, defaults -> ACT at t with BA=3 and ADDR=0x1234, rd_gnt=1 at t; RD 0101 at t+5 with ADDR=0x04AB; rd_done at t+16; busy low at t+17.
- Single write: wr_addr={3'd1,15'h0007,10'h3FF} -> WR 0100 at ACT+5 with ADDR=0x07FF; wr_done at ACT+16.
- Contention: rd_req and wr_req both high from reset, each re-requesting after done -> grants go read, write, read, write.
- Refresh: T_REFI=100, no requests -> PRE 0010 with ADDR[10]=1 on the cycle after counter wrap, REF 5 cycles later, busy for 5+44 cycles total; ref_miss stays 0.
- Refresh during access: wrap occurs during TRCD_WAIT with wr_req also pending -> read completes, then PRE/REF, then the write is granted. No overlap of commands.
